// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and round primitives for the
// compression engine and its combinational round.
package sha256_pkg;

  localparam logic [31:0] H0_INIT = 32'h6a09e667;
  localparam logic [31:0] H1_INIT = 32'hbb67ae85;
  localparam logic [31:0] H2_INIT = 32'h3c6ef372;
  localparam logic [31:0] H3_INIT = 32'ha54ff53a;
  localparam logic [31:0] H4_INIT = 32'h510e527f;
  localparam logic [31:0] H5_INIT = 32'h9b05688c;
  localparam logic [31:0] H6_INIT = 32'h1f83d9ab;
  localparam logic [31:0] H7_INIT = 32'h5be0cd19;

  localparam logic [255:0] IV = {H0_INIT, H1_INIT, H2_INIT, H3_INIT,
                                 H4_INIT, H5_INIT, H6_INIT, H7_INIT};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, ADD} state_t;

  // Working variables a..h; a occupies the top word so the struct lines up with {H0..H7}.
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } work_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: maps a..h plus K[t] and W_t to the next a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output work_t       nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = cur.h + sig1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    t2 = sig0(cur.a) + maj(cur.a, cur.b, cur.c);
    nxt.a = t1 + t2;
    nxt.b = cur.a;
    nxt.c = cur.b;
    nxt.d = cur.c;
    nxt.e = cur.d + t1;
    nxt.f = cur.e;
    nxt.g = cur.f;
    nxt.h = cur.g;
  end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: drives the message schedule, runs the rounds on
// a..h and folds the result into the chaining value H0..H7.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int NROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         first,
  input  logic [511:0] blk,
  input  logic [31:0]  m0,
  output logic [511:0] blk_out,
  output logic         ld_mreg,
  output logic         upd_mreg,
  output logic         ready,
  output logic         done,
  output logic [255:0] digest
);

  state_t         state;
  logic           first_flag;
  logic [6:0]     t;
  work_t          work;
  work_t          work_nxt;
  work_t          h_reg;
  logic [255:0]   base;
  logic [255:0]   sum;

  sha256_round u_round (
    .cur (work),
    .k   (K[t[5:0]]),
    .w   (m0),
    .nxt (work_nxt)
  );

  assign base   = first_flag ? IV : h_reg;
  assign digest = h_reg;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum[32*i +: 32] = base[32*i +: 32] + work[32*i +: 32];
    end
  end

  // Schedule controls are registered and switched on the transition into the
  // state that needs them, so they line up exactly with LOAD and ROUND.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state      <= IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      ld_mreg    <= 1'b0;
      upd_mreg   <= 1'b0;
      h_reg      <= work_t'(IV);
      work       <= '0;
      t          <= '0;
      blk_out    <= '0;
      first_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            blk_out    <= blk;
            first_flag <= first;
            ready      <= 1'b0;
            ld_mreg    <= 1'b1;
            upd_mreg   <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          work    <= first_flag ? work_t'(IV) : h_reg;
          t       <= '0;
          ld_mreg <= 1'b0;
          state   <= ROUND;
        end
        ROUND: begin
          work <= work_nxt;
          t    <= t + 7'd1;
          if (t == 7'(NROUNDS - 1)) begin
            upd_mreg <= 1'b0;
            done     <= 1'b1;
            state    <= ADD;
          end
        end
        ADD: begin
          h_reg <= work_t'(sum);
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Scoreboard bench for sha256_compress with a behavioural message schedule and
// a software-style SHA-256 reference model.
module tb_sha256_compress;
  import sha256_pkg::*;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  // The 0x80 terminator lands in word 14 of the first block; the second block carries only the length.
  localparam logic [511:0] TWO_BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2 = {480'h0, 32'h000001c0};

  logic         clk = 1'b0;
  logic         rst_b = 1'b1;
  logic         start = 1'b0;
  logic         first = 1'b0;
  logic [511:0] blk = '0;
  logic [31:0]  m0;
  logic [511:0] blk_out;
  logic         ld_mreg;
  logic         upd_mreg;
  logic         ready;
  logic         done;
  logic [255:0] digest;

  int n_checks = 0;
  int n_fails = 0;
  int busy = 0;
  int n_accept = 0;
  int n_done = 0;
  logic mon_en = 1'b0;
  logic [255:0] model_h = IV;
  logic [255:0] model_base;
  logic [255:0] exp_q [$];

  logic [2047:0] sched = '0;
  logic [6:0]    sidx = '0;

  sha256_compress #(.NROUNDS(64)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .first    (first),
    .blk      (blk),
    .m0       (m0),
    .blk_out  (blk_out),
    .ld_mreg  (ld_mreg),
    .upd_mreg (upd_mreg),
    .ready    (ready),
    .done     (done),
    .digest   (digest)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] expand(input logic [511:0] b);
    logic [31:0]   w [64];
    logic [31:0]   s0, s1;
    logic [2047:0] r;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 64; i++) r[2047 - 32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [255:0] refCompress(input logic [255:0] hin, input logic [511:0] b);
    logic [2047:0] ws;
    logic [31:0]   v [8];
    logic [31:0]   t1, t2;
    logic [255:0]  r;
    ws = expand(b);
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + ws[2047 - 32*t -: 32];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] randBlock();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Message schedule stand-in: loads on ld_mreg&upd_mreg, steps on upd_mreg.
  always @(posedge clk) begin
    if (rst_b) begin
      sidx <= '0;
    end else if (ld_mreg && upd_mreg) begin
      sched <= expand(blk_out);
      sidx  <= '0;
    end else if (upd_mreg) begin
      sidx <= sidx + 7'd1;
    end
  end
  assign m0 = sched[2047 - 32*sidx[5:0] -: 32];

  // Reference model: decides acceptance, tracks occupancy and pushes expected digests.
  initial forever begin
    @(posedge clk);
    if (rst_b) begin
      if (busy > 0) n_accept--;
      busy = 0;
      model_h = IV;
      exp_q.delete();
    end else if (busy == 0) begin
      if (start) begin
        model_base = first ? IV : model_h;
        model_h = refCompress(model_base, blk);
        exp_q.push_back(model_h);
        n_accept++;
        busy = 66;
      end
    end else begin
      busy--;
    end
  end

  // Per-cycle handshake monitor against the model's occupancy count.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("ready", 256'(ready), 256'(busy == 0));
      checkOutput("done", 256'(done), 256'(busy == 1));
      checkOutput("ld_mreg", 256'(ld_mreg), 256'(busy == 66));
      checkOutput("upd_mreg", 256'(upd_mreg), 256'(busy >= 2 && busy <= 66));
    end
  end

  // Digest monitor: each done pulse pops one expected digest.
  initial forever begin
    @(negedge clk);
    if (mon_en && done && !rst_b) begin
      n_done++;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checkOutput("scoreboard_empty", 256'(exp_q.size()), 256'(1));
      end else begin
        checkOutput("digest", digest, exp_q.pop_front());
      end
    end
  end

  task automatic doReset();
    rst_b = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    checkOutput("reset_digest", digest, IV);
    checkOutput("reset_ready", 256'(ready), 256'(1));
    checkOutput("reset_done", 256'(done), 256'(0));
    checkOutput("reset_ld_upd", 256'({ld_mreg, upd_mreg}), 256'(0));
    checkOutput("reset_blk_out", 256'(blk_out[255:0] | blk_out[511:256]), 256'(0));
  endtask

  task automatic applyStimulus(input logic [511:0] b, input logic f);
    int waited = 0;
    while (busy != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_timeout", 256'(busy == 0), 256'(1));
    start = 1'b1;
    first = f;
    blk   = b;
    @(negedge clk);
    start = 1'b0;
    first = 1'($urandom);
    blk   = randBlock();
  endtask

  task automatic waitIdle();
    int waited = 0;
    @(negedge clk);
    while (busy != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("idle_timeout", 256'(busy == 0), 256'(1));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();
    mon_en = 1'b1;

    $display("[TB] abc single block");
    applyStimulus(ABC_BLK, 1'b1);
    waitIdle();
    checkOutput("abc_kat", digest, ABC_DIGEST);

    $display("[TB] abc again with first=1");
    applyStimulus(ABC_BLK, 1'b1);
    waitIdle();
    checkOutput("abc_repeat_kat", digest, ABC_DIGEST);

    $display("[TB] two-block message");
    applyStimulus(TWO_BLK1, 1'b1);
    applyStimulus(TWO_BLK2, 1'b0);
    waitIdle();
    checkOutput("two_block_kat", digest, TWO_DIGEST);

    $display("[TB] start held high during active blocks");
    applyStimulus(randBlock(), 1'b1);
    repeat (70) begin
      start = 1'b1;
      first = 1'($urandom);
      blk   = randBlock();
      @(negedge clk);
    end
    start = 1'b0;
    waitIdle();

    $display("[TB] reset at round 30");
    applyStimulus(ABC_BLK, 1'b1);
    repeat (31) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", 256'(ready), 256'(1));
    checkOutput("abort_digest", digest, IV);
    checkOutput("abort_upd_mreg", 256'(upd_mreg), 256'(0));
    rst_b = 1'b0;
    applyStimulus(ABC_BLK, 1'b1);
    waitIdle();
    checkOutput("abc_after_abort_kat", digest, ABC_DIGEST);

    $display("[TB] first=0 straight after reset");
    doReset();
    applyStimulus(ABC_BLK, 1'b0);
    waitIdle();
    checkOutput("abc_first0_kat", digest, ABC_DIGEST);

    $display("[TB] random chained blocks");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(randBlock(), (i == 0) ? 1'b1 : 1'($urandom));
    end
    waitIdle();
    checkOutput("random_chain_final", digest, model_h);

    repeat (3) @(negedge clk);
    checkOutput("done_count", 256'(n_done), 256'(n_accept));
    checkOutput("scoreboard_drained", 256'(exp_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
